// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with valid bit, hold, bubble insert, forwarding tap and bubble counter.
// Latency: 1 cycle from EX inputs to EX_MEM_* outputs; forwarding tap is combinational from registered state.
// Backpressure: stall holds every register; flush overrides stall and squashes the control fields.
module ex_mem_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3008,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [1:0]       LS_bit,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             PctoReg,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      store_data,
    input  logic [4:0]       write_reg,
    input  logic [31:0]      ID_EX_pc_add_out,
    output logic             EX_MEM_valid,
    output logic [1:0]       EX_MEM_LS_bit,
    output logic             EX_MEM_MemtoReg,
    output logic             EX_MEM_MemWrite,
    output logic             EX_MEM_RegWrite,
    output logic             EX_MEM_PctoReg,
    output logic [31:0]      EX_MEM_alu_result,
    output logic [31:0]      EX_MEM_store_data,
    output logic [4:0]       EX_MEM_write_reg,
    output logic [31:0]      EX_MEM_pc_add_out,
    output logic             fwd_valid,
    output logic [4:0]       fwd_reg,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    // A bubble enters MEM when flushing, or when loading a non-valid EX slot.
    // Stalled cycles load nothing and so are never counted.
    logic bubble_in;
    assign bubble_in = flush | (~stall & ~ex_valid);

    // Control fields: cleared on reset and flush, held on stall, loaded otherwise.
    // Write enables are gated by ex_valid so a non-valid slot cannot write state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            EX_MEM_valid    <= 1'b0;
            EX_MEM_LS_bit   <= 2'b00;
            EX_MEM_MemtoReg <= 1'b0;
            EX_MEM_MemWrite <= 1'b0;
            EX_MEM_RegWrite <= 1'b0;
            EX_MEM_PctoReg  <= 1'b0;
        end else if (flush) begin
            EX_MEM_valid    <= 1'b0;
            EX_MEM_LS_bit   <= 2'b00;
            EX_MEM_MemtoReg <= 1'b0;
            EX_MEM_MemWrite <= 1'b0;
            EX_MEM_RegWrite <= 1'b0;
            EX_MEM_PctoReg  <= 1'b0;
        end else if (!stall) begin
            EX_MEM_valid    <= ex_valid;
            EX_MEM_LS_bit   <= LS_bit;
            EX_MEM_MemtoReg <= MemtoReg;
            EX_MEM_MemWrite <= MemWrite & ex_valid;
            EX_MEM_RegWrite <= RegWrite & ex_valid;
            EX_MEM_PctoReg  <= PctoReg;
        end
    end

    // Data fields: reset to known values, untouched by flush (the cleared valid
    // bit already makes them inert), held on stall, loaded otherwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            EX_MEM_alu_result <= 32'h0;
            EX_MEM_store_data <= 32'h0;
            EX_MEM_write_reg  <= 5'd0;
            EX_MEM_pc_add_out <= RESET_PC;
        end else if (!flush && !stall) begin
            EX_MEM_alu_result <= alu_result;
            EX_MEM_store_data <= store_data;
            EX_MEM_write_reg  <= write_reg;
            EX_MEM_pc_add_out <= ID_EX_pc_add_out;
        end
    end

    // Saturating debug counter of bubble cycles entering MEM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (bubble_in && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Forwarding tap built only from registered state. Loads still report valid;
    // load-use stalls are the hazard unit's job. Writes to $zero are never forwarded.
    always_comb begin
        fwd_valid = EX_MEM_valid & EX_MEM_RegWrite & (EX_MEM_write_reg != 5'd0);
        fwd_reg   = EX_MEM_write_reg;
        fwd_data  = EX_MEM_PctoReg ? EX_MEM_pc_add_out : EX_MEM_alu_result;
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (counter narrowed to 4 bits).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each step() advances exactly one clock.
module tb_ex_mem_reg;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [1:0]       LS_bit;
    logic             MemtoReg;
    logic             MemWrite;
    logic             RegWrite;
    logic             PctoReg;
    logic [31:0]      alu_result;
    logic [31:0]      store_data;
    logic [4:0]       write_reg;
    logic [31:0]      ID_EX_pc_add_out;
    logic             EX_MEM_valid;
    logic [1:0]       EX_MEM_LS_bit;
    logic             EX_MEM_MemtoReg;
    logic             EX_MEM_MemWrite;
    logic             EX_MEM_RegWrite;
    logic             EX_MEM_PctoReg;
    logic [31:0]      EX_MEM_alu_result;
    logic [31:0]      EX_MEM_store_data;
    logic [4:0]       EX_MEM_write_reg;
    logic [31:0]      EX_MEM_pc_add_out;
    logic             fwd_valid;
    logic [4:0]       fwd_reg;
    logic [31:0]      fwd_data;
    logic [CNT_W-1:0] bubble_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt;

    always #5 clock = ~clock;

    ex_mem_reg #(.RESET_PC(32'h0000_3008), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .ex_valid          (ex_valid),
        .LS_bit            (LS_bit),
        .MemtoReg          (MemtoReg),
        .MemWrite          (MemWrite),
        .RegWrite          (RegWrite),
        .PctoReg           (PctoReg),
        .alu_result        (alu_result),
        .store_data        (store_data),
        .write_reg         (write_reg),
        .ID_EX_pc_add_out  (ID_EX_pc_add_out),
        .EX_MEM_valid      (EX_MEM_valid),
        .EX_MEM_LS_bit     (EX_MEM_LS_bit),
        .EX_MEM_MemtoReg   (EX_MEM_MemtoReg),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_PctoReg    (EX_MEM_PctoReg),
        .EX_MEM_alu_result (EX_MEM_alu_result),
        .EX_MEM_store_data (EX_MEM_store_data),
        .EX_MEM_write_reg  (EX_MEM_write_reg),
        .EX_MEM_pc_add_out (EX_MEM_pc_add_out),
        .fwd_valid         (fwd_valid),
        .fwd_reg           (fwd_reg),
        .fwd_data          (fwd_data),
        .bubble_cnt        (bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset asserted together with stall and flush, junk on the inputs.
        reset = 1'b0; stall = 1'b1; flush = 1'b1;
        ex_valid = 1'b1; LS_bit = 2'b11; MemtoReg = 1'b1; MemWrite = 1'b1;
        RegWrite = 1'b1; PctoReg = 1'b1; alu_result = 32'hAAAA_5555;
        store_data = 32'h1111_2222; write_reg = 5'd7; ID_EX_pc_add_out = 32'h0000_9999;
        step(); step();
        check("rst_valid",    {31'h0, EX_MEM_valid},    32'h0);
        check("rst_memwrite", {31'h0, EX_MEM_MemWrite}, 32'h0);
        check("rst_regwrite", {31'h0, EX_MEM_RegWrite}, 32'h0);
        check("rst_ls",       {30'h0, EX_MEM_LS_bit},   32'h0);
        check("rst_pctoreg",  {31'h0, EX_MEM_PctoReg},  32'h0);
        check("rst_alu",      EX_MEM_alu_result,        32'h0);
        check("rst_store",    EX_MEM_store_data,        32'h0);
        check("rst_wreg",     {27'h0, EX_MEM_write_reg}, 32'h0);
        check("rst_pc",       EX_MEM_pc_add_out,        32'h0000_3008);
        check("rst_fwdv",     {31'h0, fwd_valid},       32'h0);
        check("rst_fwdd",     fwd_data,                 32'h0);
        check("rst_bubble",   {28'h0, bubble_cnt},      32'h0);

        // Plain ALU instruction load.
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_valid = 1'b1; LS_bit = 2'b00; MemtoReg = 1'b0; MemWrite = 1'b0;
        RegWrite = 1'b1; PctoReg = 1'b0; alu_result = 32'h0000_1234;
        store_data = 32'h0; write_reg = 5'd8; ID_EX_pc_add_out = 32'h0000_3010;
        step();
        check("ld_valid",  {31'h0, EX_MEM_valid}, 32'h1);
        check("ld_fwdv",   {31'h0, fwd_valid},    32'h1);
        check("ld_fwdreg", {27'h0, fwd_reg},      32'd8);
        check("ld_fwdd",   fwd_data,              32'h0000_1234);
        check("ld_pc",     EX_MEM_pc_add_out,     32'h0000_3010);
        check("ld_bubble", {28'h0, bubble_cnt},   32'h0);

        // jal-style: forward PC+4 instead of the ALU result.
        PctoReg = 1'b1; write_reg = 5'd31;
        step();
        check("jal_fwdreg", {27'h0, fwd_reg}, 32'd31);
        check("jal_fwdd",   fwd_data,         32'h0000_3010);

        // Store, then hold for 3 cycles while the inputs change.
        PctoReg = 1'b0; RegWrite = 1'b0; MemWrite = 1'b1; LS_bit = 2'b11;
        alu_result = 32'h0000_0040; store_data = 32'hDEAD_BEEF; write_reg = 5'd0;
        ID_EX_pc_add_out = 32'h0000_3014;
        step();
        check("st_memwrite", {31'h0, EX_MEM_MemWrite}, 32'h1);
        check("st_alu",      EX_MEM_alu_result,        32'h0000_0040);
        check("st_fwdv",     {31'h0, fwd_valid},       32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_valid = i[0]; MemWrite = 1'b0; RegWrite = 1'b1; LS_bit = 2'b01;
            alu_result = 32'h0000_0999 + i; store_data = 32'h0BAD_0000 + i;
            write_reg = 5'd20 + i[4:0]; ID_EX_pc_add_out = 32'h0000_5000 + i;
            step();
            check("stall_valid",    {31'h0, EX_MEM_valid},    32'h1);
            check("stall_memwrite", {31'h0, EX_MEM_MemWrite}, 32'h1);
            check("stall_alu",      EX_MEM_alu_result,        32'h0000_0040);
            check("stall_store",    EX_MEM_store_data,        32'hDEAD_BEEF);
            check("stall_ls",       {30'h0, EX_MEM_LS_bit},   32'h3);
            check("stall_pc",       EX_MEM_pc_add_out,        32'h0000_3014);
            check("stall_bubble",   {28'h0, bubble_cnt},      32'h0);
        end

        // Valid RegWrite instruction, then stall+flush together.
        stall = 1'b0; ex_valid = 1'b1; RegWrite = 1'b1; MemWrite = 1'b0; LS_bit = 2'b00;
        alu_result = 32'h0000_5555; store_data = 32'h0; write_reg = 5'd9;
        ID_EX_pc_add_out = 32'h0000_3018;
        step();
        check("pre_fl_fwdv", {31'h0, fwd_valid}, 32'h1);
        stall = 1'b1; flush = 1'b1; alu_result = 32'h0000_6666; write_reg = 5'd10;
        step();
        check("fl_valid",    {31'h0, EX_MEM_valid},    32'h0);
        check("fl_regwrite", {31'h0, EX_MEM_RegWrite}, 32'h0);
        check("fl_fwdv",     {31'h0, fwd_valid},       32'h0);
        check("fl_bubble",   {28'h0, bubble_cnt},      32'h1);
        check("fl_alu_hold", EX_MEM_alu_result,        32'h0000_5555);
        check("fl_wreg_hold", {27'h0, EX_MEM_write_reg}, 32'd9);

        // Non-valid slot with write enables set must not write anything.
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; MemWrite = 1'b1; RegWrite = 1'b1;
        alu_result = 32'h0000_0777; write_reg = 5'd4;
        step();
        check("gate_memwrite", {31'h0, EX_MEM_MemWrite}, 32'h0);
        check("gate_regwrite", {31'h0, EX_MEM_RegWrite}, 32'h0);
        check("gate_valid",    {31'h0, EX_MEM_valid},    32'h0);
        check("gate_alu",      EX_MEM_alu_result,        32'h0000_0777);
        check("gate_bubble",   {28'h0, bubble_cnt},      32'h2);

        // Write to $zero is never forwarded.
        ex_valid = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; write_reg = 5'd0;
        step();
        check("zero_regwrite", {31'h0, EX_MEM_RegWrite}, 32'h1);
        check("zero_fwdv",     {31'h0, fwd_valid},       32'h0);
        check("zero_bubble",   {28'h0, bubble_cnt},      32'h2);

        // Loads still forward.
        MemtoReg = 1'b1; write_reg = 5'd3; alu_result = 32'h0000_0100;
        step();
        check("lw_fwdv", {31'h0, fwd_valid}, 32'h1);
        check("lw_fwdd", fwd_data,           32'h0000_0100);

        // 20 consecutive bubbles saturate the 4-bit counter.
        MemtoReg = 1'b0; ex_valid = 1'b0;
        exp_cnt = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_cnt < 15) exp_cnt++;
            check("sat_bubble", {28'h0, bubble_cnt}, exp_cnt);
        end

        // Reset mid-run, then one more bubble.
        reset = 1'b0;
        step();
        check("rst2_bubble", {28'h0, bubble_cnt}, 32'h0);
        check("rst2_pc",     EX_MEM_pc_add_out,   32'h0000_3008);
        reset = 1'b1;
        step();
        check("post_rst_bubble", {28'h0, bubble_cnt}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the multistage MIPS datapath.
- Captures the ALU result, store data, destination register, PC+4 and the MEM/WB control bits carried from ID/EX.
- Adds a valid bit, stall (hold) and flush (bubble) control.
- Exposes a registered forwarding tap for the EX-stage forwarding unit and a saturating bubble counter for debug.

Parameters:
- RESET_PC, 32'h0000_3008, reset value of EX_MEM_pc_add_out.
- CNT_W, 16, width of the bubble counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  1 = hold all registers (MEM stage busy / hazard unit stall).
- flush  in  1  1 = load a bubble (branch/jump redirect resolved in EX).
- ex_valid  in  1  EX stage holds a real instruction.
- LS_bit  in  2  load/store size code.
- MemtoReg  in  1  write-back selects memory data.
- MemWrite  in  1  data memory write enable.
- RegWrite  in  1  register file write enable.
- PctoReg  in  1  write-back selects PC+4 (jal).
- alu_result  in  32  ALU output / effective address.
- store_data  in  32  forwarded rt value for stores.
- write_reg  in  5  destination register after RegDst mux.
- ID_EX_pc_add_out  in  32  PC+4 of the instruction in EX.
- EX_MEM_valid  out  1  MEM stage holds a real instruction.
- EX_MEM_LS_bit  out  2  registered LS_bit.
- EX_MEM_MemtoReg  out  1  registered MemtoReg.
- EX_MEM_MemWrite  out  1  registered MemWrite, gated by valid.
- EX_MEM_RegWrite  out  1  registered RegWrite, gated by valid.
- EX_MEM_PctoReg  out  1  registered PctoReg.
- EX_MEM_alu_result  out  32  registered ALU result.
- EX_MEM_store_data  out  32  registered store data.
- EX_MEM_write_reg  out  5  registered destination register.
- EX_MEM_pc_add_out  out  32  registered PC+4.
- fwd_valid  out  1  forwarding tap is usable.
- fwd_reg  out  5  forwarding destination register.
- fwd_data  out  32  forwarding value.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Priority at each posedge: reset==0, then flush, then stall, then load.
- Reset (reset==0 at posedge):
  - All outputs 0, except EX_MEM_pc_add_out = RESET_PC.
  - bubble_cnt = 0.
  - Applies even during stall or flush.
- Flush (flush==1 and reset==1):
  - EX_MEM_valid, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_PctoReg and EX_MEM_LS_bit go to 0.
  - Data fields (alu_result, store_data, write_reg, pc_add_out) keep their previous values.
  - Flush overrides a simultaneous stall.
- Stall (stall==1, flush==0): every register holds its value, including EX_MEM_valid.
- Load (stall==0, flush==0):
  - All fields take their inputs, 1-cycle latency.
  - EX_MEM_valid = ex_valid.
  - EX_MEM_MemWrite = MemWrite & ex_valid; EX_MEM_RegWrite = RegWrite & ex_valid.
  - A non-valid input therefore can never write memory or the register file.
- Forwarding tap (combinational from registered state only, no input-to-output path):
  - fwd_valid = EX_MEM_valid & EX_MEM_RegWrite & (EX_MEM_write_reg != 0).
  - fwd_reg = EX_MEM_write_reg.
  - fwd_data = EX_MEM_PctoReg ? EX_MEM_pc_add_out : EX_MEM_alu_result.
  - Loads (MemtoReg==1) still assert fwd_valid. The hazard unit, not this block, must stall load-use.
- bubble_cnt:
  - Increments by 1 on each posedge where reset==1 and the register is not stalled and the newly loaded EX_MEM_valid is 0 (flush, or load with ex_valid==0).
  - Saturates at all-ones; never wraps.
  - Stalled cycles are not counted.
- No X propagation: every output is defined from the first reset onward.

Test Plan:
- Reset: hold reset=0 for 2 cycles with stall=1, flush=1 → all outputs 0, EX_MEM_pc_add_out=32'h0000_3008, bubble_cnt=0.
- Load: ex_valid=1, RegWrite=1, write_reg=5'd8, alu_result=32'h0000_1234, pc=32'h0000_3010 → next cycle EX_MEM_valid=1, fwd_valid=1, fwd_reg=8, fwd_data=32'h0000_1234. Then PctoReg=1, write_reg=31 → fwd_data=32'h0000_3010.
- Stall: load a store (MemWrite=1, alu_result=32'h40), then stall=1 for 3 cycles while inputs change → outputs unchanged for all 3 cycles, bubble_cnt unchanged.
- Flush with stall: stall=1 and flush=1 together while holding a valid RegWrite instruction → next cycle EX_MEM_valid=0, EX_MEM_RegWrite=0, fwd_valid=0, bubble_cnt +1.
- Gating and $zero: ex_valid=0 with MemWrite=1 → EX_MEM_MemWrite=0, bubble_cnt +1. ex_valid=1, RegWrite=1, write_reg=0 → fwd_valid=0.
- Saturation: with CNT_W=4, drive 20 consecutive bubbles → bubble_cnt stops at 4'hF. Reset mid-run → 0 on the next posedge.
